alu_mul_unit: RTL and testbench
===============================

ALU_MUL_UNIT -- requirements
Module: alu_mul_unit

Interface
REQ-001 clk  input  1  single clock; all state changes on its rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 cycle  input  1  bus cycle valid from the arbitration interconnect.
REQ-004 strobe  input  1  operation request; qualified by cycle.
REQ-005 op  input  9  operation code; op[1:0] selects the function, op[8:2] reserved and ignored.
REQ-006 al, bl  input  18 each  left-lane signed multiplicands.
REQ-007 cl  input  48  left-lane signed addend.
REQ-008 ar, br  input  18 each  right-lane signed multiplicands.
REQ-009 cr  input  48  right-lane signed addend.
REQ-010 ack  output  1  one-cycle result-valid pulse.
REQ-011 stall  output  1  request not accepted this cycle.
REQ-012 pl, pr  output  48 each  registered left/right results; also the per-lane accumulators.

Function
REQ-013 Accept occurs on an edge where cycle & strobe & ~stall = 1; operands and op are captured into registers on that edge.
REQ-014 strobe with cycle=0 is ignored.
REQ-015 FSM states: IDLE, MUL, ADD, ACK; IDLE -accept-> MUL; MUL -> ADD; ADD -> ACK; ACK -accept-> MUL, else -> IDLE.
REQ-016 stall = 1 in MUL and ADD; stall = 0 in IDLE and ACK.
REQ-017 MUL registers the 36-bit signed products al*bl and ar*br, sign-extended to 48 bits.
REQ-018 ADD computes per lane, by op[1:0]: 00 P=A*B; 01 P=A*B+C; 10 P=C-A*B; 11 P=Pprev+A*B, with Pprev the current pl/pr value. pl/pr load on the ADD->ACK edge.
REQ-019 ack = 1 only in ACK, exactly one clock period, i.e. the third period after the accept edge (latency 3). Back-to-back throughput is one operation per 3 cycles.
REQ-020 pl/pr hold their value between ACKs and are never cleared by an ordinary operation.
REQ-021 Both lanes always execute the same op concurrently.
REQ-022 Abort: if cycle = 0 in MUL or ADD, the FSM returns to IDLE on the next edge; pl/pr are not updated and no ack is issued.
REQ-023 The accepting edge from ACK carries the new transaction; the ack of the completing transaction is not suppressed.

Reset
REQ-024 Asserting reset, at any time including mid-operation, immediately forces state=IDLE, ack=0, stall=0, pl=pr=48'h0, and clears operand and product registers.
REQ-025 An operation in flight at reset is discarded with no ack. The first accept is possible on the first edge after reset deasserts.

Configuration
REQ-026 Macro ALU_MUL_SATURATE_EN, when defined: any 48-bit signed overflow in ADD clamps to 48'h7FFF_FFFF_FFFF (positive) or 48'h8000_0000_0000 (negative).
REQ-027 Without ALU_MUL_SATURATE_EN: results wrap modulo 2^48 and no saturation logic is synthesised.

Verification
REQ-028 Single op: op=01, al=3, bl=4, cl=5 -> ack exactly 3 periods after accept; pl=48'd17; stall=1 for 2 cycles.
REQ-029 Signed and dual-lane op: op=00, al=-2, bl=3, ar=100, br=-100 -> pl=48'hFFFF_FFFF_FFFA, pr=48'hFFFF_FFFF_D8F0.
REQ-030 Accumulate: op=00 with al=2, bl=5, then back-to-back op=11 accepted in ACK with al=1, bl=7 -> first ack pl=10; second ack pl=17; accept edges 3 cycles apart.
REQ-031 Overflow: op=01, cl=48'h7FFF_FFFF_FFFF, al=bl=1 -> pl=48'h7FFF_FFFF_FFFF with the macro; pl=48'h8000_0000_0000 without it.
REQ-032 Abort and reset: drop cycle while in MUL -> no ack and pl unchanged. Separately, assert reset while in ADD -> outputs zero immediately and no ack follows.

Source files
------------

// File: rtl/alu_mul_unit.sv
// Dual-lane 18x18 signed multiply / multiply-add unit with per-lane 48-bit accumulators.
// Optional macro ALU_MUL_SATURATE_EN clamps 48-bit signed overflow instead of wrapping.
module alu_mul_unit (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cycle,
    input  logic        i_strobe,
    input  logic [8:0]  i_op,
    input  logic [17:0] i_al,
    input  logic [17:0] i_bl,
    input  logic [47:0] i_cl,
    input  logic [17:0] i_ar,
    input  logic [17:0] i_br,
    input  logic [47:0] i_cr,
    output logic        o_ack,
    output logic        o_stall,
    output logic [47:0] o_pl,
    output logic [47:0] o_pr
);

    typedef enum logic [1:0] {IDLE, MUL, ADD, ACK} state_t;

    state_t             r_state, w_next;
    logic [1:0]         r_op;
    logic [17:0]        r_al, r_bl, r_ar, r_br;
    logic [47:0]        r_cl, r_cr;
    logic [47:0]        r_prodl, r_prodr;
    logic [47:0]        r_pl, r_pr;
    logic               w_accept;
    logic signed [35:0] w_mull, w_mulr;
    logic [47:0]        w_resl, w_resr;
    logic               w_unused_op;

    // op[8:2] are reserved; folded into a deliberately unused net.
    assign w_unused_op = ^i_op[8:2];

    // 49-bit intermediate catches any single 48-bit signed overflow.
    function automatic logic [47:0] lane_res(input logic [1:0]  op,
                                             input logic [47:0] prod,
                                             input logic [47:0] c,
                                             input logic [47:0] prev);
        logic signed [48:0] p, cc, v, s;
        p  = {prod[47], prod};
        cc = {c[47], c};
        v  = {prev[47], prev};
        case (op)
            2'b00:   s = p;
            2'b01:   s = p + cc;
            2'b10:   s = cc - p;
            default: s = v + p;
        endcase
`ifdef ALU_MUL_SATURATE_EN
        if (s[48] != s[47])
            return s[48] ? 48'h8000_0000_0000 : 48'h7FFF_FFFF_FFFF;
`endif
        return s[47:0];
    endfunction

    assign o_stall  = (r_state == MUL) || (r_state == ADD);
    assign o_ack    = (r_state == ACK);
    assign o_pl     = r_pl;
    assign o_pr     = r_pr;
    assign w_accept = i_cycle & i_strobe & ~o_stall;
    assign w_mull   = $signed(r_al) * $signed(r_bl);
    assign w_mulr   = $signed(r_ar) * $signed(r_br);
    assign w_resl   = lane_res(r_op, r_prodl, r_cl, r_pl);
    assign w_resr   = lane_res(r_op, r_prodr, r_cr, r_pr);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = MUL;
            MUL:     w_next = i_cycle ? ADD : IDLE;
            ADD:     w_next = i_cycle ? ACK : IDLE;
            ACK:     w_next = w_accept ? MUL : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_al    <= '0;
            r_bl    <= '0;
            r_ar    <= '0;
            r_br    <= '0;
            r_cl    <= '0;
            r_cr    <= '0;
            r_prodl <= '0;
            r_prodr <= '0;
            r_pl    <= '0;
            r_pr    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op <= i_op[1:0];
                r_al <= i_al;
                r_bl <= i_bl;
                r_ar <= i_ar;
                r_br <= i_br;
                r_cl <= i_cl;
                r_cr <= i_cr;
            end
            if (r_state == MUL) begin
                r_prodl <= {{12{w_mull[35]}}, w_mull};
                r_prodr <= {{12{w_mulr[35]}}, w_mulr};
            end
            // Aborted transactions (cycle dropped in ADD) leave the accumulators untouched.
            if (r_state == ADD && i_cycle) begin
                r_pl <= w_resl;
                r_pr <= w_resr;
            end
        end
    end

endmodule

// File: tb/tb_alu_mul_unit.sv
// Scoreboard bench for alu_mul_unit: driver pushes expected results, monitor checks on ack.
module tb_alu_mul_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cycle = 1'b0;
    logic        strobe = 1'b0;
    logic [8:0]  op = '0;
    logic [17:0] al = '0, bl = '0, ar = '0, br = '0;
    logic [47:0] cl = '0, cr = '0;
    logic        ack, stall;
    logic [47:0] pl, pr;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [47:0] pl;
        logic [47:0] pr;
        int          acc;
    } exp_t;
    exp_t q[$];

    alu_mul_unit dut (
        .i_clk(clk), .i_reset(reset), .i_cycle(cycle), .i_strobe(strobe), .i_op(op),
        .i_al(al), .i_bl(bl), .i_cl(cl), .i_ar(ar), .i_br(br), .i_cr(cr),
        .o_ack(ack), .o_stall(stall), .o_pl(pl), .o_pr(pr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ack) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pl", pl, e.pl);
                chk("pr", pr, e.pr);
                chk("latency", 48'(cyc - e.acc), 48'd2);
            end
        end
    end

    task automatic issue(input logic [8:0] o, input logic [17:0] a_l, b_l, input logic [47:0] c_l,
                         input logic [17:0] a_r, b_r, input logic [47:0] c_r,
                         input bit expect_ack, input logic [47:0] epl, epr, output int acc);
        int n;
        exp_t e;
        op = o; al = a_l; bl = b_l; cl = c_l; ar = a_r; br = b_r; cr = c_r;
        cycle = 1'b1;
        strobe = 1'b1;
        n = 0;
        @(negedge clk);
        while (stall && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("accept_timeout", 48'(n), 48'd0);
        @(posedge clk);
        #1;
        acc = cyc;
        strobe = 1'b0;
        if (expect_ack) begin
            e.pl = epl; e.pr = epr; e.acc = acc;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        int a0, a1, rel;
        logic [47:0] ovl, ovr;
`ifdef ALU_MUL_SATURATE_EN
        ovl = 48'h7FFF_FFFF_FFFF;
        ovr = 48'h8000_0000_0000;
`else
        ovl = 48'h8000_0000_0000;
        ovr = 48'h7FFF_FFFF_FFFF;
`endif
        #1;
        chk("rst_pl", pl, 48'h0);
        chk("rst_pr", pr, 48'h0);
        chk("rst_ack", {47'h0, ack}, 48'h0);
        chk("rst_stall", {47'h0, stall}, 48'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Multiply-add with reserved op bits set; stall for exactly two cycles.
        issue(9'b1010101_01, 18'd3, 18'd4, 48'd5, -18'sd3, 18'd4, 48'd10, 1, 48'd17,
              48'hFFFF_FFFF_FFFE, a0);
        @(negedge clk); chk("stall_mul", {47'h0, stall}, 48'h1);
        @(negedge clk); chk("stall_add", {47'h0, stall}, 48'h1);
        @(negedge clk); chk("stall_ack", {47'h0, stall}, 48'h0);
        idle(2);

        // C - A*B
        issue(9'd2, 18'd5, 18'd6, 48'd100, 18'd2, 18'd3, 48'd0, 1, 48'd70,
              48'hFFFF_FFFF_FFFA, a0);
        idle(4);

        // Signed dual-lane product
        issue(9'd0, -18'sd2, 18'd3, 48'd999, 18'd100, -18'sd100, 48'd7, 1,
              48'hFFFF_FFFF_FFFA, 48'hFFFF_FFFF_D8F0, a0);
        idle(4);

        // Extreme operand magnitudes
        issue(9'd0, 18'h20000, 18'h20000, 48'd0, 18'h1FFFF, 18'h20000, 48'd0, 1,
              48'h0004_0000_0000, 48'hFFFC_0002_0000, a0);
        idle(4);

        // Back-to-back accumulate, second request accepted in ACK
        issue(9'd0, 18'd2, 18'd5, 48'd0, 18'd1, 18'd1, 48'd0, 1, 48'd10, 48'd1, a0);
        issue(9'd3, 18'd1, 18'd7, 48'd0, 18'd2, 18'd2, 48'd0, 1, 48'd17, 48'd5, a1);
        chk("b2b_spacing", 48'(a1 - a0), 48'd3);
        idle(5);

        // Overflow in both directions
        issue(9'd1, 18'd1, 18'd1, 48'h7FFF_FFFF_FFFF, 18'd1, -18'sd1, 48'h8000_0000_0000, 1,
              ovl, ovr, a0);
        idle(5);

        // strobe without cycle is ignored
        cycle = 1'b0;
        strobe = 1'b1;
        @(negedge clk); chk("nocyc_stall0", {47'h0, stall}, 48'h0);
        @(negedge clk); chk("nocyc_stall1", {47'h0, stall}, 48'h0);
        strobe = 1'b0;
        idle(4);

        // Abort: drop cycle while in MUL
        issue(9'd0, 18'd9, 18'd9, 48'd0, 18'd9, 18'd9, 48'd0, 0, 48'd0, 48'd0, a0);
        cycle = 1'b0;
        idle(6);
        chk("abort_pl", pl, ovl);
        chk("abort_pr", pr, ovr);
        chk("abort_stall", {47'h0, stall}, 48'h0);

        // Reset while in ADD
        issue(9'd0, 18'd9, 18'd9, 48'd0, 18'd9, 18'd9, 48'd0, 0, 48'd0, 48'd0, a0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rstadd_pl", pl, 48'h0);
        chk("rstadd_pr", pr, 48'h0);
        chk("rstadd_ack", {47'h0, ack}, 48'h0);
        chk("rstadd_stall", {47'h0, stall}, 48'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        rel = cyc;

        // First accept on the first edge after reset release
        issue(9'd1, 18'd3, 18'd4, 48'd5, 18'd0, 18'd0, 48'd0, 1, 48'd17, 48'd0, a0);
        chk("post_rst_accept", 48'(a0 - rel), 48'd1);
        idle(6);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_ack: got %0d outstanding expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1);
    end

endmodule
